// File: rtl/stage5_writeback_stage_pkg.sv
// Shared stage5 pipeline records and writeback FSM encoding.
package stage5_writeback_stage_pkg;

  localparam int unsigned WB_XLEN = 32;
  localparam int unsigned RD_W    = 5;

  // Writeback sequencer states
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef logic [1:0] wb_state_t;

  // EX/MEM pipeline record
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [RD_W-1:0]    rd;
    logic [WB_XLEN-1:0] alu_result;
    logic [WB_XLEN-1:0] store_data;
    logic [WB_XLEN-1:0] pc;
    logic               halt;
  } ex_mem_t;

  // MEM/WB pipeline record
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic [RD_W-1:0]    rd;
    logic [WB_XLEN-1:0] rd_data;
    logic [WB_XLEN-1:0] pc;
    logic               halt;
  } mem_wb_t;

  // Empty MEM/WB slot
  function automatic mem_wb_t mem_wb_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/stage5_retire_counter.sv
// Retired-instruction counter with a per-entry "already counted" flag so a
// stalled entry retires exactly once.
module stage5_retire_counter #(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_valid,
  input  logic                 i_count_en,
  output logic                 o_retire,
  output logic [INSTRET_W-1:0] o_instret
);

  logic                 r_counted;
  logic [INSTRET_W-1:0] r_instret;

  assign o_retire  = i_valid & ~r_counted;
  assign o_instret = r_instret;

  // Flag clears on every new load; counter wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counted <= 1'b0;
      r_instret <= '0;
    end else begin
      if (i_load) begin
        r_counted <= 1'b0;
      end else if (o_retire) begin
        r_counted <= 1'b1;
      end
      if (o_retire && i_count_en) begin
        r_instret <= r_instret + INSTRET_W'(1);
      end
    end
  end

endmodule

// File: rtl/stage5_writeback_stage.sv
// Writeback stage: MEM/WB register, register-file write port, retire
// counting and halt sequencing (optional dcache drain before halting).
module stage5_writeback_stage
  import stage5_writeback_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INSTRET_W  = 64,
  parameter string       HALT_FLUSH = "enabled"
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 mem_wb_stall,
  input  logic                 mem_wb_flush,
  input  logic                 m_valid,
  input  logic                 m_reg_write,
  input  logic [4:0]           m_rd,
  input  logic [XLEN-1:0]      m_rd_data,
  input  logic [XLEN-1:0]      m_pc,
  input  logic                 m_halt,
  input  logic                 dflush_done,
  output logic                 rf_wen,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 retire,
  output logic [XLEN-1:0]      wb_pc,
  output logic [INSTRET_W-1:0] instret,
  output logic                 dflush_req,
  output logic                 halt_stall,
  output logic                 halt
);

  localparam bit FLUSH_EN = (HALT_FLUSH == "enabled");

  mem_wb_t   r_mem_wb;
  mem_wb_t   w_mem_in;
  wb_state_t r_state;
  wb_state_t w_state_next;
  logic      r_dflush_req;
  logic      w_dflush_req_next;
  logic      w_run;
  logic      w_retire;
  logic      w_halt_go;
  logic      w_load;

  assign w_run     = (r_state == ST_RUN);
  assign w_halt_go = w_run & w_retire & r_mem_wb.halt;
  // Register freezes outside RUN and on the halt-retire cycle itself
  assign w_load    = w_run & ~w_halt_go & (mem_wb_flush | ~mem_wb_stall);

  // Incoming record; a flush replaces it with a bubble
  always_comb begin
    w_mem_in = mem_wb_bubble();
    if (!mem_wb_flush) begin
      w_mem_in.valid     = m_valid;
      w_mem_in.reg_write = m_reg_write;
      w_mem_in.rd        = m_rd;
      w_mem_in.rd_data   = WB_XLEN'(m_rd_data);
      w_mem_in.pc        = WB_XLEN'(m_pc);
      w_mem_in.halt      = m_halt;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mem_wb <= mem_wb_bubble();
    end else if (w_load) begin
      r_mem_wb <= w_mem_in;
    end
  end

  // Halt sequencer state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= ST_RUN;
      r_dflush_req <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_dflush_req <= w_dflush_req_next;
    end
  end

  // Halt sequencer next state; flush request pulses on entry to FLUSH
  always_comb begin
    w_state_next      = r_state;
    w_dflush_req_next = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_halt_go) begin
          if (FLUSH_EN) begin
            w_state_next      = ST_FLUSH;
            w_dflush_req_next = 1'b1;
          end else begin
            w_state_next = ST_HALTED;
          end
        end
      end
      ST_FLUSH: begin
        if (dflush_done) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_RUN;
    endcase
  end

  stage5_retire_counter #(
    .INSTRET_W (INSTRET_W)
  ) u_cnt (
    .clk        (CLK),
    .rst_n      (nRST),
    .i_load     (w_load),
    .i_valid    (r_mem_wb.valid),
    .i_count_en (r_state != ST_HALTED),
    .o_retire   (w_retire),
    .o_instret  (instret)
  );

  assign rf_wen     = r_mem_wb.valid & r_mem_wb.reg_write & (r_mem_wb.rd != 5'd0);
  assign rf_rd      = r_mem_wb.rd;
  assign rf_wdata   = XLEN'(r_mem_wb.rd_data);
  assign retire     = w_retire;
  assign wb_pc      = XLEN'(r_mem_wb.pc);
  assign dflush_req = r_dflush_req;
  assign halt_stall = ~w_run | w_halt_go;
  assign halt       = (r_state == ST_HALTED);

endmodule

// File: tb/tb_stage5_writeback_stage.sv
// Randomized bench for the writeback stage: one instance with dcache drain
// before halt and one halting immediately, both checked against a
// behavioural model each cycle.
module tb_stage5_writeback_stage;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST;
  logic        mem_wb_stall, mem_wb_flush;
  logic        m_valid, m_reg_write, m_halt, dflush_done;
  logic [4:0]  m_rd;
  logic [31:0] m_rd_data, m_pc;

  logic        o_rf_wen     [2];
  logic [4:0]  o_rf_rd      [2];
  logic [31:0] o_rf_wdata   [2];
  logic        o_retire     [2];
  logic [31:0] o_wb_pc      [2];
  logic [63:0] o_instret    [2];
  logic        o_dflush_req [2];
  logic        o_halt_stall [2];
  logic        o_halt       [2];

  stage5_writeback_stage #(.XLEN(32), .INSTRET_W(64), .HALT_FLUSH("enabled")) dut (
    .CLK(CLK), .nRST(nRST), .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd), .m_rd_data(m_rd_data),
    .m_pc(m_pc), .m_halt(m_halt), .dflush_done(dflush_done),
    .rf_wen(o_rf_wen[0]), .rf_rd(o_rf_rd[0]), .rf_wdata(o_rf_wdata[0]), .retire(o_retire[0]),
    .wb_pc(o_wb_pc[0]), .instret(o_instret[0]), .dflush_req(o_dflush_req[0]),
    .halt_stall(o_halt_stall[0]), .halt(o_halt[0]));

  stage5_writeback_stage #(.XLEN(32), .INSTRET_W(64), .HALT_FLUSH("disabled")) dut_nf (
    .CLK(CLK), .nRST(nRST), .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd), .m_rd_data(m_rd_data),
    .m_pc(m_pc), .m_halt(m_halt), .dflush_done(dflush_done),
    .rf_wen(o_rf_wen[1]), .rf_rd(o_rf_rd[1]), .rf_wdata(o_rf_wdata[1]), .retire(o_retire[1]),
    .wb_pc(o_wb_pc[1]), .instret(o_instret[1]), .dflush_req(o_dflush_req[1]),
    .halt_stall(o_halt_stall[1]), .halt(o_halt[1]));

  // Behavioural model: the entry in WB, whether it is new this cycle,
  // the halt phase (0 running, 1 draining, 2 halted) and the retire count.
  typedef struct {
    bit        v, rw, h;
    bit [4:0]  rd;
    bit [31:0] data, pc;
    bit        fresh;
    int        ph;
    bit        first;
    bit [63:0] cnt;
  } mdl_t;

  mdl_t m [2];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i] = '{v:0, rw:0, h:0, rd:0, data:0, pc:0, fresh:1, ph:0, first:0, cnt:0};
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit ret, go;
      ret = m[i].v & m[i].fresh;
      go  = (m[i].ph == 0) & ret & m[i].h;
      chk($sformatf("rf_wen%0d", i),     64'(o_rf_wen[i]),     64'(m[i].v & m[i].rw & (m[i].rd != 0)));
      chk($sformatf("rf_rd%0d", i),      64'(o_rf_rd[i]),      64'(m[i].rd));
      chk($sformatf("rf_wdata%0d", i),   64'(o_rf_wdata[i]),   64'(m[i].data));
      chk($sformatf("retire%0d", i),     64'(o_retire[i]),     64'(ret));
      chk($sformatf("wb_pc%0d", i),      64'(o_wb_pc[i]),      64'(m[i].pc));
      chk($sformatf("instret%0d", i),    o_instret[i],         m[i].cnt);
      chk($sformatf("dflush_req%0d", i), 64'(o_dflush_req[i]), 64'((m[i].ph == 1) & m[i].first));
      chk($sformatf("halt_stall%0d", i), 64'(o_halt_stall[i]), 64'((m[i].ph != 0) | go));
      chk($sformatf("halt%0d", i),       64'(o_halt[i]),       64'(m[i].ph == 2));
    end
  endtask

  // Advance the model by one clock using the currently driven inputs
  task automatic step_model();
    for (int i = 0; i < 2; i++) begin
      bit ret, go;
      ret = m[i].v & m[i].fresh;
      go  = (m[i].ph == 0) & ret & m[i].h;
      if (ret && m[i].ph != 2) m[i].cnt = m[i].cnt + 64'd1;
      if (m[i].ph == 0 && !go && (mem_wb_flush || !mem_wb_stall)) begin
        if (mem_wb_flush) begin
          m[i].v = 0; m[i].rw = 0; m[i].h = 0; m[i].rd = 0; m[i].data = 0; m[i].pc = 0;
        end else begin
          m[i].v = m_valid; m[i].rw = m_reg_write; m[i].h = m_halt;
          m[i].rd = m_rd; m[i].data = m_rd_data; m[i].pc = m_pc;
        end
        m[i].fresh = 1;
      end else begin
        m[i].fresh = 0;
      end
      if (go) begin
        m[i].ph    = (i == 0) ? 1 : 2;
        m[i].first = (i == 0);
      end else if (m[i].ph == 1) begin
        m[i].first = 0;
        if (dflush_done) m[i].ph = 2;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    step_model();
    @(negedge CLK);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge CLK);
    nRST = 1'b1;
    #1 check_all();
  endtask

  task automatic drive(input bit v, input bit rw, input bit [4:0] rd, input bit [31:0] d,
                       input bit [31:0] pc, input bit h, input bit st, input bit fl, input bit dn);
    m_valid = v; m_reg_write = rw; m_rd = rd; m_rd_data = d; m_pc = pc; m_halt = h;
    mem_wb_stall = st; mem_wb_flush = fl; dflush_done = dn;
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 3) != 0, 1'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
          $urandom, $urandom, $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
  endtask

  initial begin
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    tick();

    // Basic load and retire
    drive(1, 1, 5'd5, 32'hDEADBEEF, 32'h100, 0, 0, 0, 0);
    tick();
    chk("dir_wen", 64'(o_rf_wen[0]), 64'd1);
    chk("dir_wdata", 64'(o_rf_wdata[0]), 64'hDEADBEEF);
    chk("dir_retire", 64'(o_retire[0]), 64'd1);
    // Hold it for three cycles while upstream presents other data
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 5'd9, $urandom, $urandom, 0, 1, 0, 0);
      tick();
      chk("dir_hold_instret", o_instret[0], 64'd1);
    end
    // rd=0 entry retires without a write
    drive(1, 1, 5'd0, 32'h1234, 32'h104, 0, 0, 0, 0);
    tick();
    chk("dir_rd0_wen", 64'(o_rf_wen[0]), 64'd0);
    // Flush beats stall
    drive(1, 1, 5'd7, 32'h55, 32'h108, 0, 1, 1, 0);
    tick();
    chk("dir_flush_retire", 64'(o_retire[0]), 64'd0);

    // Halt with drain completing four cycles later
    drive(1, 0, 5'd0, 0, 32'h10C, 1, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 5'd3, $urandom, $urandom, 0, 0, 0, 0);
      tick();
    end
    drive(1, 1, 5'd3, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 1, 5'd3, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("dir_halted", 64'(o_halt[0]), 64'd1);

    // Reset during the drain
    do_reset();
    drive(1, 0, 5'd0, 0, 32'h200, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    do_reset();

    // Counter wrap from all-ones
    force dut.u_cnt.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.u_cnt.r_instret;
    m[0].cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1, 1, 5'd4, 32'hA5A5, 32'h300, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("dir_wrap", o_instret[0], 64'd0);

    // Randomized traffic with resets mid-drain and after both halt
    for (int n = 0; n < 3000; n++) begin
      if ((m[0].ph == 1 && $urandom_range(0, 3) == 0) || (m[0].ph == 2 && m[1].ph == 2))
        do_reset();
      drive_random();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
